// File: rtl/fp_fcsr_ctrl.sv
// FP control/status register block: frm/fflags storage, CSR access sequencing behind
// in-flight FP ops, and rounding-mode resolution. Define FP_FCSR_DIRTY_EN for FS-dirty tracking.
module fp_fcsr_ctrl #(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        csr_req_valid_i,
    output logic        csr_req_ready_o,
    input  logic [1:0]  csr_op_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_rsp_valid_o,
    output logic [31:0] csr_rdata_o,
    output logic        csr_err_o,
    input  logic        fpu_issue_i,
    input  logic        fpu_done_i,
    input  logic [4:0]  fpu_fflags_i,
    output logic        fpu_stall_o,
    input  logic [2:0]  instr_rm_i,
    output logic [2:0]  frm_o,
    output logic [4:0]  fflags_o,
    output logic [2:0]  rm_eff_o,
    output logic        rm_illegal_o
`ifdef FP_FCSR_DIRTY_EN
    ,
    input  logic        fs_clean_i,
    output logic        fs_dirty_o
`endif
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, DRAIN, EXEC, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    frm_q, frm_d;
    logic [4:0]    fflags_q, fflags_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [1:0]    op_q;
    logic [11:0]   addr_q;
    logic [7:0]    wdata_q;
    logic          accept;
    logic [7:0]    fcsr_upd, frm_upd;
    logic          unused_wdata;

    // Only the low byte of the operand can reach any field.
    assign unused_wdata = ^csr_wdata_i[31:8];

    function automatic logic [7:0] apply_op(logic [1:0] op, logic [7:0] old, logic [7:0] wd);
        case (op)
            2'b01:   return wd;
            2'b10:   return old | wd;
            2'b11:   return old & ~wd;
            default: return old;
        endcase
    endfunction

    assign accept   = csr_req_valid_i && (state_q == IDLE);
    assign fcsr_upd = apply_op(op_q, {frm_q, fflags_q}, wdata_q);
    assign frm_upd  = apply_op(op_q, {5'b0, frm_q}, wdata_q);

    always_comb begin
        cnt_d = cnt_q;
        if (fpu_issue_i && !fpu_done_i && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_ONE;
        else if (fpu_done_i && !fpu_issue_i && (cnt_q != '0))
            cnt_d = cnt_q - CNT_ONE;
    end

    always_comb begin
        state_d  = state_q;
        frm_d    = frm_q;
        fflags_d = fflags_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        if (fpu_done_i)
            fflags_d = fflags_q | fpu_fflags_i;
        case (state_q)
            IDLE:  if (accept) state_d = (cnt_d != '0) ? DRAIN : EXEC;
            DRAIN: if (cnt_d == '0) state_d = EXEC;
            EXEC: begin
                // The CSR access owns the flags this cycle; a stray retirement is lost.
                fflags_d = fflags_q;
                err_d    = 1'b0;
                state_d  = RESP;
                case (addr_q)
                    12'h001: begin
                        rdata_d  = {27'b0, fflags_q};
                        fflags_d = fcsr_upd[4:0];
                    end
                    12'h002: begin
                        rdata_d = {29'b0, frm_q};
                        frm_d   = frm_upd[2:0];
                    end
                    12'h003: begin
                        rdata_d  = {24'b0, frm_q, fflags_q};
                        frm_d    = fcsr_upd[7:5];
                        fflags_d = fcsr_upd[4:0];
                    end
                    default: begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end
                endcase
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            frm_q    <= '0;
            fflags_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            op_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            frm_q    <= frm_d;
            fflags_q <= fflags_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            if (accept) begin
                op_q    <= csr_op_i;
                addr_q  <= csr_addr_i;
                wdata_q <= csr_wdata_i[7:0];
            end
        end
    end

    assign csr_req_ready_o = (state_q == IDLE);
    assign csr_rsp_valid_o = (state_q == RESP);
    assign csr_rdata_o     = rdata_q;
    assign csr_err_o       = err_q;
    assign fpu_stall_o     = (cnt_q == CNT_MAX) || (state_q != IDLE) || csr_req_valid_i;
    assign frm_o           = frm_q;
    assign fflags_o        = fflags_q;

    // rm=7 selects the dynamic mode; reserved encodings are flagged, never remapped.
    assign rm_eff_o     = (instr_rm_i == 3'd7) ? frm_q : instr_rm_i;
    assign rm_illegal_o = (instr_rm_i == 3'd5) || (instr_rm_i == 3'd6) ||
                          ((instr_rm_i == 3'd7) && (frm_q >= 3'd5));

`ifdef FP_FCSR_DIRTY_EN
    logic dirty_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            dirty_q <= 1'b0;
        else if ((frm_d != frm_q) || (fflags_d != fflags_q))
            dirty_q <= 1'b1;
        else if (fs_clean_i)
            dirty_q <= 1'b0;
    end

    assign fs_dirty_o = dirty_q;
`endif

endmodule

// File: tb/tb_fp_fcsr_ctrl.sv
// Directed bench for fp_fcsr_ctrl: a transaction-level model is checked every cycle,
// and literal expectations pin key results.
module tb_fp_fcsr_ctrl;
    localparam int MAXO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        csr_req_valid_i = 1'b0;
    logic        csr_req_ready_o;
    logic [1:0]  csr_op_i = '0;
    logic [11:0] csr_addr_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic        csr_rsp_valid_o;
    logic [31:0] csr_rdata_o;
    logic        csr_err_o;
    logic        fpu_issue_i = 1'b0;
    logic        fpu_done_i = 1'b0;
    logic [4:0]  fpu_fflags_i = '0;
    logic        fpu_stall_o;
    logic [2:0]  instr_rm_i = '0;
    logic [2:0]  frm_o;
    logic [4:0]  fflags_o;
    logic [2:0]  rm_eff_o;
    logic        rm_illegal_o;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    fp_fcsr_ctrl #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .csr_req_valid_i(csr_req_valid_i), .csr_req_ready_o(csr_req_ready_o),
        .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_rsp_valid_o(csr_rsp_valid_o), .csr_rdata_o(csr_rdata_o), .csr_err_o(csr_err_o),
        .fpu_issue_i(fpu_issue_i), .fpu_done_i(fpu_done_i), .fpu_fflags_i(fpu_fflags_i),
        .fpu_stall_o(fpu_stall_o), .instr_rm_i(instr_rm_i),
        .frm_o(frm_o), .fflags_o(fflags_o), .rm_eff_o(rm_eff_o), .rm_illegal_o(rm_illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          m_cnt;
    logic [2:0]  m_frm;
    logic [4:0]  m_fflags;
    bit          m_busy, m_wait, m_exec, m_rsp;
    logic [1:0]  t_op;
    logic [11:0] t_addr;
    logic [31:0] t_wd;
    logic [31:0] m_rdata;
    logic        m_err;

    task automatic model_reset();
        m_cnt = 0; m_frm = '0; m_fflags = '0;
        m_busy = 0; m_wait = 0; m_exec = 0; m_rsp = 0;
        m_rdata = '0; m_err = 1'b0;
    endtask

    task automatic model_step();
        int cnt_n, sh;
        bit was_exec, was_rsp, was_busy, ok;
        logic [7:0] v, mask, old, wd, nw;
        was_exec = m_exec; was_rsp = m_rsp; was_busy = m_busy;
        m_exec = 0; m_rsp = 0;
        cnt_n = m_cnt;
        if (fpu_issue_i && !fpu_done_i && m_cnt < MAXO) cnt_n = m_cnt + 1;
        if (fpu_done_i && !fpu_issue_i && m_cnt > 0) cnt_n = m_cnt - 1;
        if (fpu_done_i && !was_exec) m_fflags = m_fflags | fpu_fflags_i;
        if (was_exec) begin
            // fcsr viewed as one byte {frm,fflags}; each address is a window onto it
            v = {m_frm, m_fflags}; ok = 1; sh = 0; mask = 8'h00;
            case (t_addr)
                12'h001: begin sh = 0; mask = 8'h1F; end
                12'h002: begin sh = 5; mask = 8'h07; end
                12'h003: begin sh = 0; mask = 8'hFF; end
                default: ok = 0;
            endcase
            if (ok) begin
                old = (v >> sh) & mask;
                wd  = t_wd[7:0] & mask;
                case (t_op)
                    2'b01:   nw = wd;
                    2'b10:   nw = old | wd;
                    2'b11:   nw = old & ~wd & mask;
                    default: nw = old;
                endcase
                v = (v & ~(mask << sh)) | (nw << sh);
                m_frm = v[7:5]; m_fflags = v[4:0];
                m_rdata = {24'b0, old}; m_err = 1'b0;
            end else begin
                m_rdata = '0; m_err = 1'b1;
            end
            m_rsp = 1;
        end
        if (was_rsp) m_busy = 0;
        if (!was_busy && csr_req_valid_i) begin
            t_op = csr_op_i; t_addr = csr_addr_i; t_wd = csr_wdata_i;
            m_busy = 1;
            if (cnt_n == 0) m_exec = 1; else m_wait = 1;
        end else if (m_wait && cnt_n == 0) begin
            m_wait = 0; m_exec = 1;
        end
        m_cnt = cnt_n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) model_reset();
            else model_step();
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk_i) begin
        if (rst_ni) begin
            chk("cyc_rsp_valid", 32'(csr_rsp_valid_o), 32'(m_rsp));
            if (m_rsp) begin
                chk("cyc_rdata", csr_rdata_o, m_rdata);
                chk("cyc_err", 32'(csr_err_o), 32'(m_err));
            end
            chk("cyc_ready", 32'(csr_req_ready_o), 32'(!m_busy));
            chk("cyc_stall", 32'(fpu_stall_o), 32'((m_cnt == MAXO) || m_busy || csr_req_valid_i));
            chk("cyc_frm", 32'(frm_o), 32'(m_frm));
            chk("cyc_fflags", 32'(fflags_o), 32'(m_fflags));
            chk("cyc_rm_eff", 32'(rm_eff_o), 32'((instr_rm_i == 3'd7) ? m_frm : instr_rm_i));
            chk("cyc_rm_ill", 32'(rm_illegal_o),
                32'((instr_rm_i == 3'd5) || (instr_rm_i == 3'd6) || (instr_rm_i == 3'd7 && m_frm > 3'd4)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
    endtask

    task automatic csr_send(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
        bit got;
        got = 0;
        csr_req_valid_i = 1'b1; csr_op_i = op; csr_addr_i = addr; csr_wdata_i = wd;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk_i);
            got = csr_req_ready_o;
            tick();
        end
        csr_req_valid_i = 1'b0;
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_rsp(input string name, input logic [31:0] exp_rd, input logic exp_err,
                            output int lat);
        bit got;
        got = 0; lat = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk_i);
            if (csr_rsp_valid_o) begin
                got = 1; lat = i + 1;
                chk({name, "_rdata"}, csr_rdata_o, exp_rd);
                chk({name, "_err"}, 32'(csr_err_o), 32'(exp_err));
            end
        end
        if (!got) chk({name, "_timeout"}, 32'd0, 32'd1);
        tick();
    endtask

    initial begin
        int lat, nrsp;
        repeat (3) tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_rsp_valid", 32'(csr_rsp_valid_o), 32'd0);
        chk("rst_rdata", csr_rdata_o, 32'd0);
        chk("rst_err", 32'(csr_err_o), 32'd0);
        chk("rst_frm", 32'(frm_o), 32'd0);
        chk("rst_fflags", 32'(fflags_o), 32'd0);
        chk("rst_ready", 32'(csr_req_ready_o), 32'd1);
        chk("rst_stall", 32'(fpu_stall_o), 32'd0);
        tick();

        // RW fcsr from idle: minimum latency, field split
        csr_send(2'b01, 12'h003, 32'h0000_00E3);
        wait_rsp("rw_fcsr", 32'h0, 1'b0, lat);
        chk("rw_fcsr_latency", 32'(lat), 32'd2);
        @(negedge clk_i);
        chk("rw_fcsr_frm", 32'(frm_o), 32'd7);
        chk("rw_fcsr_fflags", 32'(fflags_o), 32'd3);
        tick();

        // read-only, clear, field reads
        csr_send(2'b00, 12'h003, 32'hFFFF_FFFF);
        wait_rsp("ro_fcsr", 32'hE3, 1'b0, lat);
        csr_send(2'b11, 12'h003, 32'hFFFF_FF21);
        wait_rsp("rc_fcsr", 32'hE3, 1'b0, lat);
        csr_send(2'b00, 12'h002, 32'h0);
        wait_rsp("ro_frm", 32'h6, 1'b0, lat);
        csr_send(2'b00, 12'h001, 32'h0);
        wait_rsp("ro_fflags", 32'h2, 1'b0, lat);

        // drain: two ops in flight, flags accumulate before the set
        do_reset();
        fpu_issue_i = 1'b1; repeat (2) tick(); fpu_issue_i = 1'b0;
        csr_send(2'b10, 12'h001, 32'h10);
        fpu_done_i = 1'b1; fpu_fflags_i = 5'h01; tick();
        fpu_fflags_i = 5'h04; tick();
        fpu_done_i = 1'b0; fpu_fflags_i = 5'h00;
        wait_rsp("drain_rs", 32'h05, 1'b0, lat);
        @(negedge clk_i);
        chk("drain_fflags", 32'(fflags_o), 32'h15);
        tick();

        // rounding-mode resolution
        csr_send(2'b01, 12'h002, 32'h3);
        wait_rsp("frm3", 32'h0, 1'b0, lat);
        instr_rm_i = 3'd7; @(negedge clk_i);
        chk("dyn_rm_eff", 32'(rm_eff_o), 32'd3);
        chk("dyn_rm_ill", 32'(rm_illegal_o), 32'd0);
        tick();
        csr_send(2'b01, 12'h002, 32'hFFFF_FFF5);
        wait_rsp("frm5", 32'h3, 1'b0, lat);
        @(negedge clk_i);
        chk("frm5_stored", 32'(frm_o), 32'd5);
        chk("frm5_rm_ill", 32'(rm_illegal_o), 32'd1);
        tick();
        instr_rm_i = 3'd6; @(negedge clk_i);
        chk("rm6_ill", 32'(rm_illegal_o), 32'd1);
        tick();
        instr_rm_i = 3'd2; @(negedge clk_i);
        chk("rm2_eff", 32'(rm_eff_o), 32'd2);
        chk("rm2_ill", 32'(rm_illegal_o), 32'd0);
        tick();

        // outstanding counter saturation and simultaneous issue/done
        fpu_issue_i = 1'b1; repeat (5) tick(); fpu_issue_i = 1'b0;
        @(negedge clk_i);
        chk("sat_stall", 32'(fpu_stall_o), 32'd1);
        tick();
        fpu_issue_i = 1'b1; fpu_done_i = 1'b1; tick();
        fpu_issue_i = 1'b0; fpu_done_i = 1'b0;
        @(negedge clk_i);
        chk("both_stall", 32'(fpu_stall_o), 32'd1);
        tick();
        fpu_done_i = 1'b1; tick(); fpu_done_i = 1'b0;
        @(negedge clk_i);
        chk("dec_stall", 32'(fpu_stall_o), 32'd0);
        tick();
        fpu_done_i = 1'b1; repeat (4) tick(); fpu_done_i = 1'b0;

        // unsupported address
        csr_send(2'b01, 12'h300, 32'hFF);
        wait_rsp("bad_addr", 32'h0, 1'b1, lat);
        @(negedge clk_i);
        chk("bad_addr_frm", 32'(frm_o), 32'd5);
        chk("bad_addr_fflags", 32'(fflags_o), 32'h15);
        tick();
        csr_send(2'b00, 12'h001, 32'h0);
        wait_rsp("after_err", 32'h15, 1'b0, lat);

        // reset while draining aborts the access
        fpu_issue_i = 1'b1; tick(); fpu_issue_i = 1'b0;
        csr_send(2'b01, 12'h002, 32'h1);
        do_reset();
        nrsp = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (csr_rsp_valid_o) nrsp++;
        end
        chk("abort_no_rsp", 32'(nrsp), 32'd0);
        chk("abort_frm", 32'(frm_o), 32'd0);
        chk("abort_ready", 32'(csr_req_ready_o), 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
